// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, line idle level and default frame parameters.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam logic        UART_IDLE_LEVEL       = 1'b1;
    localparam int unsigned UART_DEF_DATA_BITS    = 8;
    localparam int unsigned UART_DEF_CLKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_RX_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP,
        RX_WAIT_IDLE
    } uart_rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for asynchronous inputs, with a configurable reset value.
module uart_sync2 #(
    parameter int unsigned      WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_deser.sv
// UART receive deserializer: synchronised rx, mid-bit sampling, valid/ready output with
// framing-error and overrun flags. Optional parity checking under UART_RX_PARITY_EN.
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS    = UART_DEF_DATA_BITS,
    parameter int unsigned CLKS_PER_BIT = UART_DEF_CLKS_PER_BIT
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit          PARITY_ODD   = 1'b0
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 frame_err,
    output logic                 overrun,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 busy
);

    localparam int unsigned       BCNT_W    = $clog2(CLKS_PER_BIT);
    localparam int unsigned       BIDX_W    = $clog2(DATA_BITS + 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BCNT_W-1:0] BCNT_HALF = BCNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(DATA_BITS - 1);

    logic                 rxs;
    uart_rx_state_t       state, state_n;
    logic [BCNT_W-1:0]    bcnt;
    logic [BIDX_W-1:0]    bidx;
    logic [DATA_BITS-1:0] shreg;
    logic                 cnt_run, bcnt_clr, bidx_clr, shift_en, frame_done;
    logic                 done_q, done_ferr;
    logic [DATA_BITS-1:0] done_data;
`ifdef UART_RX_PARITY_EN
    logic                 par_en, par_q, done_perr;
`endif

    uart_sync2 #(
        .WIDTH     (1),
        .RESET_VAL (UART_IDLE_LEVEL)
    ) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rxs)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= RX_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n    = state;
        cnt_run    = 1'b0;
        bcnt_clr   = 1'b0;
        bidx_clr   = 1'b0;
        shift_en   = 1'b0;
        frame_done = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_en     = 1'b0;
`endif
        case (state)
            RX_IDLE: begin
                if (!rxs) begin
                    state_n  = RX_START;
                    bcnt_clr = 1'b1;
                end
            end
            RX_START: begin
                cnt_run = 1'b1;
                if (bcnt == BCNT_HALF) begin
                    bcnt_clr = 1'b1;
                    bidx_clr = 1'b1;
                    state_n  = rxs ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                cnt_run = 1'b1;
                if (bcnt == BCNT_LAST) begin
                    bcnt_clr = 1'b1;
                    shift_en = 1'b1;
                    if (bidx == BIDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_n = RX_PARITY;
`else
                        state_n = RX_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                cnt_run = 1'b1;
                if (bcnt == BCNT_LAST) begin
                    bcnt_clr = 1'b1;
                    par_en   = 1'b1;
                    state_n  = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                cnt_run = 1'b1;
                if (bcnt == BCNT_LAST) begin
                    bcnt_clr   = 1'b1;
                    frame_done = 1'b1;
                    state_n    = rxs ? RX_IDLE : RX_WAIT_IDLE;
                end
            end
            RX_WAIT_IDLE: begin
                if (rxs) state_n = RX_IDLE;
            end
            default: state_n = RX_IDLE;
        endcase
    end

    assign busy = (state != RX_IDLE);

    always_ff @(posedge clk) begin
        if (rst || bcnt_clr || !cnt_run) bcnt <= '0;
        else                             bcnt <= bcnt + BCNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bidx  <= '0;
            shreg <= '0;
        end else if (bidx_clr) begin
            bidx  <= '0;
        end else if (shift_en) begin
            bidx  <= bidx + BIDX_W'(1);
            shreg <= {rxs, shreg[DATA_BITS-1:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst)         par_q <= 1'b0;
        else if (par_en) par_q <= rxs;
    end
`endif

    // Completed frame is staged for one cycle; the output register loads from this stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q    <= 1'b0;
            done_data <= '0;
            done_ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
            done_perr <= 1'b0;
`endif
        end else begin
            done_q <= frame_done;
            if (frame_done) begin
                done_data <= shreg;
                done_ferr <= ~rxs;
`ifdef UART_RX_PARITY_EN
                done_perr <= (^shreg) ^ par_q ^ PARITY_ODD;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            overrun <= 1'b0;
            if (done_q && (!out_valid || out_ready)) begin
                out_data   <= done_data;
                frame_err  <= done_ferr;
                out_valid  <= 1'b1;
`ifdef UART_RX_PARITY_EN
                parity_err <= done_perr;
`endif
            end else if (done_q) begin
                overrun <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed self-checking bench for uart_rx_deser (default parameters; parity test under UART_RX_PARITY_EN).
module tb_uart_rx_deser;

    localparam int unsigned N = 8;
    localparam int unsigned C = 16;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned P = 1;
`else
    localparam int unsigned P = 0;
`endif
    localparam int LAT = C/2 + N*C + C + 3 + P*C;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rx = 1'b1;
    logic         out_ready = 1'b0;
    logic [N-1:0] out_data;
    logic         out_valid, frame_err, overrun, busy;
`ifdef UART_RX_PARITY_EN
    logic         parity_err;
    logic         par_flip = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    uart_rx_deser #(
        .DATA_BITS    (N),
        .CLKS_PER_BIT (C)
`ifdef UART_RX_PARITY_EN
        ,
        .PARITY_ODD   (1'b0)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation log: accepted words, valid edges and overrun pulses.
    logic [N-1:0] acc_data[$];
    logic         acc_ferr[$];
    logic         acc_perr[$];
    int           n_rise = 0, n_ovr = 0, rise_cyc = 0, fall_cyc = 0;
    logic         pv = 1'b0;

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            acc_data.push_back(out_data);
            acc_ferr.push_back(frame_err);
`ifdef UART_RX_PARITY_EN
            acc_perr.push_back(parity_err);
`else
            acc_perr.push_back(1'b0);
`endif
        end
        if (out_valid && !pv) begin
            n_rise++;
            rise_cyc = cyc;
        end
        if (!out_valid && pv) fall_cyc = cyc;
        if (overrun) n_ovr++;
        pv = out_valid;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        step(C);
    endtask

    task automatic send_frame(input logic [N-1:0] d, input logic stopb);
        drive_bit(1'b0);
        for (int i = 0; i < N; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ par_flip);
`endif
        drive_bit(stopb);
    endtask

    function automatic logic [N-1:0] word_at(input int idx);
        return (acc_data.size() > idx) ? acc_data[idx] : 'x;
    endfunction

    function automatic logic ferr_at(input int idx);
        return (acc_ferr.size() > idx) ? acc_ferr[idx] : 1'bx;
    endfunction

    task automatic test_reset;
        rst = 1'b1; rx = 1'b1; out_ready = 1'b0;
        step(3);
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected %h", out_data, 8'h00); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
`ifdef UART_RX_PARITY_EN
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b expected 0", parity_err); end
`endif
        rst = 1'b0;
        step(5);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_basic;
        int n0, r0, c0;
        out_ready = 1'b1;
        step(2);
        n0 = acc_data.size(); r0 = n_rise; c0 = cyc;
        send_frame(8'hA5, 1'b1);
        step(10);
        checks++; if (rise_cyc - (c0 + 1) !== LAT) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", rise_cyc - (c0 + 1), LAT); end
        checks++; if (fall_cyc - rise_cyc !== 1) begin errors++; $display("FAIL basic_pulse_width: got %0d expected 1", fall_cyc - rise_cyc); end
        checks++; if (n_rise - r0 !== 1) begin errors++; $display("FAIL basic_frames: got %0d expected 1", n_rise - r0); end
        checks++; if (word_at(n0) !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h expected a5", word_at(n0)); end
        checks++; if (ferr_at(n0) !== 1'b0) begin errors++; $display("FAIL basic_ferr: got %b expected 0", ferr_at(n0)); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_glitch;
        int r0;
        r0 = n_rise;
        rx = 1'b0;
        step(4);
        rx = 1'b1;
        step(2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start: got %b expected 1", busy); end
        step(6);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_cleared: got %b expected 0", busy); end
        step(30);
        checks++; if (n_rise - r0 !== 0) begin errors++; $display("FAIL glitch_no_output: got %0d expected 0", n_rise - r0); end
    endtask

    task automatic test_frame_err;
        int n0, r0;
        out_ready = 1'b1;
        n0 = acc_data.size(); r0 = n_rise;
        send_frame(8'h3C, 1'b0);
        rx = 1'b0;
        step(40);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL break_wait_idle: got busy %b expected 1", busy); end
        rx = 1'b1;
        step(5);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_release: got busy %b expected 0", busy); end
        step(200);
        checks++; if (n_rise - r0 !== 1) begin errors++; $display("FAIL ferr_frames: got %0d expected 1", n_rise - r0); end
        checks++; if (word_at(n0) !== 8'h3C) begin errors++; $display("FAIL ferr_data: got %h expected 3c", word_at(n0)); end
        checks++; if (ferr_at(n0) !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b expected 1", ferr_at(n0)); end
    endtask

    task automatic test_overrun;
        int n0, r0, o0;
        out_ready = 1'b0;
        step(2);
        n0 = acc_data.size(); r0 = n_rise; o0 = n_ovr;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        step(20);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid_held: got %b expected 1", out_valid); end
        checks++; if (out_data !== 8'h11) begin errors++; $display("FAIL ovr_data_kept: got %h expected 11", out_data); end
        checks++; if (n_ovr - o0 !== 1) begin errors++; $display("FAIL ovr_pulses: got %0d expected 1", n_ovr - o0); end
        checks++; if (n_rise - r0 !== 1) begin errors++; $display("FAIL ovr_rises: got %0d expected 1", n_rise - r0); end
        out_ready = 1'b1;
        step(1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovr_accept_clears: got %b expected 0", out_valid); end
        checks++; if (acc_data.size() - n0 !== 1) begin errors++; $display("FAIL ovr_accepted_count: got %0d expected 1", acc_data.size() - n0); end
        checks++; if (word_at(n0) !== 8'h11) begin errors++; $display("FAIL ovr_accepted_word: got %h expected 11", word_at(n0)); end
    endtask

    task automatic test_back_to_back;
        int n0, o0;
        out_ready = 1'b1;
        n0 = acc_data.size(); o0 = n_ovr;
        send_frame(8'h81, 1'b1);
        send_frame(8'h7E, 1'b1);
        step(20);
        checks++; if (acc_data.size() - n0 !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", acc_data.size() - n0); end
        checks++; if (word_at(n0) !== 8'h81) begin errors++; $display("FAIL b2b_first: got %h expected 81", word_at(n0)); end
        checks++; if (word_at(n0 + 1) !== 8'h7E) begin errors++; $display("FAIL b2b_second: got %h expected 7e", word_at(n0 + 1)); end
        checks++; if (n_ovr - o0 !== 0) begin errors++; $display("FAIL b2b_overrun: got %0d expected 0", n_ovr - o0); end
    endtask

    task automatic test_reset_midframe;
        int n0, r0;
        out_ready = 1'b1;
        n0 = acc_data.size(); r0 = n_rise;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
        rst = 1'b1;
        step(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_after_rst: got %b expected 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid_after_rst: got %b expected 0", out_valid); end
        rst = 1'b0;
        rx = 1'b1;
        step(40);
        send_frame(8'h5A, 1'b1);
        step(20);
        checks++; if (n_rise - r0 !== 1) begin errors++; $display("FAIL mid_frames: got %0d expected 1", n_rise - r0); end
        checks++; if (word_at(n0) !== 8'h5A) begin errors++; $display("FAIL mid_data: got %h expected 5a", word_at(n0)); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int n0;
        out_ready = 1'b1;
        n0 = acc_perr.size();
        par_flip = 1'b0;
        send_frame(8'h07, 1'b1);
        step(10);
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        step(10);
        par_flip = 1'b0;
        checks++; if (acc_perr.size() - n0 !== 2) begin errors++; $display("FAIL par_count: got %0d expected 2", acc_perr.size() - n0); end
        checks++; if (word_at(n0) !== 8'h07) begin errors++; $display("FAIL par_data: got %h expected 07", word_at(n0)); end
        checks++; if (((acc_perr.size() > n0) ? acc_perr[n0] : 1'bx) !== 1'b0) begin errors++; $display("FAIL par_good: got %b expected 0", (acc_perr.size() > n0) ? acc_perr[n0] : 1'bx); end
        checks++; if (((acc_perr.size() > n0 + 1) ? acc_perr[n0 + 1] : 1'bx) !== 1'b1) begin errors++; $display("FAIL par_bad: got %b expected 1", (acc_perr.size() > n0 + 1) ? acc_perr[n0 + 1] : 1'bx); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_back_to_back();
        test_reset_midframe();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_deser.md
# uart_rx_deser

Parametrised UART receive deserializer: it replaces the bare clock-gated 8-stage shift register in the UART receive path. It runs on the system clock with an internal bit-period counter, synchronises the asynchronous `rx` line and detects the start bit. It samples each data bit at mid-bit, checks the stop bit, and presents the assembled word on a valid/ready output with framing-error and overrun flags. It sits between the `rx` pad and the receive FIFO or host register.

## Interface
- `DATA_BITS`, 8: data bits per frame, 5..9, LSB first on the line.
- `CLKS_PER_BIT`, 16: clock cycles per bit period, even, ≥ 4.
- `clk`  in  1: system clock; everything is on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `rx`  in  1: asynchronous serial line; idle high.
- `out_data`  out  DATA_BITS: received word, bit 0 = first bit on the line.
- `out_valid`  out  1: word available; held until accepted.
- `out_ready`  in  1: consumer accepts the word when `out_valid && out_ready`.
- `frame_err`  out  1: qualified by `out_valid`; stop bit was sampled 0.
- `overrun`  out  1: one-cycle pulse; a completed frame was dropped.
- `busy`  out  1: high in every state other than IDLE.

## Operation
- `rx` passes through a 2-FF synchroniser, reset to 1. All decisions use the synchronised value `rxs`.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: if `rxs == 0`, go to START and clear the bit counter `bcnt`.
- START: after CLKS_PER_BIT/2 cycles, resample `rxs`.
  - `rxs == 0`: go to DATA and clear `bcnt`.
  - `rxs == 1`: false start; return to IDLE with no output.
- DATA: every CLKS_PER_BIT cycles, sample `rxs` into the MSB of the shift register, shift right, and increment the bit index.
  - After DATA_BITS samples, go to STOP.
- STOP: after CLKS_PER_BIT cycles, sample `rxs`.
  - 1: return to IDLE.
  - 0: go to WAIT_IDLE.
  - In both cases the frame completes on this cycle.
- WAIT_IDLE: stay until `rxs == 1`, then go to IDLE. This covers a break condition and prevents a spurious start.
- Frame completion:
  - If `out_valid == 0` or `out_ready == 1` this cycle: load `out_data` and `frame_err` (= stop sample was 0), and set `out_valid`.
  - Otherwise: keep the old word, drop the new one, and pulse `overrun`.
- `out_valid` clears on `out_valid && out_ready` unless a new frame loads in the same cycle. Accept and load in the same cycle means `out_valid` stays 1 with the new data.
- Reset mid-frame: on the next edge the FSM is in IDLE, all counters are 0 and `out_valid` is 0. The partial frame is discarded.

## Timing
- Reset values:
  - `out_data` = 0, `out_valid` = 0, `frame_err` = 0, `overrun` = 0, `busy` = 0.
  - Synchroniser flops = 1.
- Input latency: 2 cycles of synchroniser delay before the FSM sees an `rx` edge.
- Start-to-output: with C = CLKS_PER_BIT and N = DATA_BITS, `out_valid` rises C/2 + N·C + C + 3 cycles after the first clock edge that samples `rx` low.
  - Defaults: 155 cycles.
- Back-to-back frames: a new start bit immediately after a good stop sample is accepted. Inter-frame idle time is C/2 (end of stop bit), which is acceptable.
- `bcnt` counts 0..C-1 and its width is $clog2(CLKS_PER_BIT). The bit index width is $clog2(DATA_BITS+1).

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Adds state PARITY between DATA and STOP, sampled like a data bit.
  - Adds parameter `PARITY_ODD` (default 0, meaning even parity).
  - Adds output `parity_err`, qualified by `out_valid` and loaded together with `frame_err`: 1 if the XOR of the data bits and the parity sample mismatches the selected parity.
  - Start-to-output latency grows by C.
- `UART_RX_PARITY_EN` undefined: no PARITY state, no `parity_err` port, no `PARITY_ODD` parameter.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum `uart_rx_state_t`.
  - `UART_IDLE_LEVEL` = 1'b1.
  - Default-parameter constants shared with the future transmitter.
- One sub-module: `uart_sync2`, the 2-FF synchroniser with a reset value parameter. It is reused for other asynchronous inputs.
- Shift register, counters and output register live in `uart_rx_deser`. No gated clocks.

## Test plan
- Defaults; send 0xA5 with a good stop bit and `out_ready` = 1 → `out_valid` pulses for one cycle at cycle 155, `out_data` = 0xA5, `frame_err` = 0.
- Glitch: `rx` low for 4 cycles, then high → no `out_valid`; `busy` returns to 0 by cycle 11.
- Send 0x3C with stop bit = 0, then hold `rx` low for 40 cycles → `out_data` = 0x3C, `frame_err` = 1. The FSM stays in WAIT_IDLE until `rx` rises, and no extra frame is produced.
- `out_ready` = 0; send 0x11 then 0x22 back-to-back → `out_data` stays 0x11 and `overrun` pulses once. Raising `out_ready` clears `out_valid`.
- Assert `rst` in the middle of the DATA state of 0xFF, release it, then send 0x5A → only 0x5A is output.
- With `UART_RX_PARITY_EN` defined and `PARITY_ODD` = 0: send 0x07 with parity bit 1 → `parity_err` = 0; send 0x07 with parity bit 0 → `parity_err` = 1.
